qam16_judge: RTL and testbench

Symbol decision and serialisation stage of the QAM16 receiver. It sits directly downstream of the baseband mean (gate level) stage.
- On each symbol strobe it slices the demodulated I and Q baseband samples against the gate levels 0 and ±mean into a 4-bit Gray-coded symbol.
- It then shifts that symbol out as a serial bit stream for the descrambler/frame stage.
- A one-deep pending buffer absorbs strobe jitter; a sticky flag reports lost symbols.

---
 rtl/qam16_pkg.sv | 17 +
 rtl/qam16_slicer.sv | 31 +++
 rtl/qam16_judge.sv | 116 +++++++++++
 tb/tb_qam16_judge.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam16_pkg.sv
// Shared types and constants for the QAM16 decision/serialiser stage.
package qam16_pkg;

    localparam int DW = 26;

    // Gray-coded amplitude levels, most negative to most positive
    localparam logic [1:0] L_N3 = 2'b00;
    localparam logic [1:0] L_N1 = 2'b01;
    localparam logic [1:0] L_P1 = 2'b11;
    localparam logic [1:0] L_P3 = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/qam16_slicer.sv
// Per-axis slicer: compares one baseband sample against 0 and +/-gate level.
module qam16_slicer
    import qam16_pkg::*;
(
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] m,
    output logic        [1:0]    code
);

    logic signed [DW:0] xe;
    logic signed [DW:0] ge;
    logic signed [DW:0] gn;

    // One extra bit so negating the largest positive gate level cannot wrap
    always_comb begin
        xe = {x[DW-1], x};
        ge = m[DW-1] ? '0 : {1'b0, m};
        gn = -ge;
        if (ge == '0)
            code = x[DW-1] ? L_N1 : L_P3;
        else if (xe < gn)
            code = L_N3;
        else if (x[DW-1])
            code = L_N1;
        else if (xe < ge)
            code = L_P1;
        else
            code = L_P3;
    end

endmodule

// File: rtl/qam16_judge.sv
// QAM16 symbol decision plus MSB-first serialiser with a one-deep pending buffer.
//   state    | meaning
//   ST_IDLE  | no symbol on the serial line, bit_vld low
//   ST_SHIFT | shifting shreg out, each bit held DIV cycles
module qam16_judge
    import qam16_pkg::*;
#(
    parameter int DIV = 2
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] din_q,
    input  logic signed [DW-1:0] mean_i,
    input  logic signed [DW-1:0] mean_q,
    input  logic                 sym_stb,
    output logic        [3:0]    sym,
    output logic                 sym_vld,
    output logic                 bit_out,
    output logic                 bit_vld,
    output logic                 overrun
);

    localparam logic [7:0] D_LAST = 8'(DIV - 1);

    logic [1:0] code_i;
    logic [1:0] code_q;
    state_t     state;
    logic [3:0] shreg;
    logic [3:0] pend;
    logic       pend_full;
    logic [1:0] b;
    logic [7:0] d;
    logic       fin;

    qam16_slicer u_slice_i (.x(din_i), .m(mean_i), .code(code_i));
    qam16_slicer u_slice_q (.x(din_q), .m(mean_q), .code(code_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym     <= '0;
            sym_vld <= 1'b0;
        end else begin
            sym_vld <= sym_stb;
            if (sym_stb)
                sym <= {code_i, code_q};
        end
    end

    // Last hold cycle of bit 0: the symbol boundary
    assign fin = (d == '0) && (b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            b         <= '0;
            d         <= '0;
            bit_out   <= 1'b0;
            bit_vld   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sym_vld) begin
                        state   <= ST_SHIFT;
                        shreg   <= sym;
                        b       <= 2'd3;
                        d       <= D_LAST;
                        bit_out <= sym[3];
                        bit_vld <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (d != '0) begin
                        d <= d - 8'd1;
                    end else if (b != '0) begin
                        b       <= b - 2'd1;
                        d       <= D_LAST;
                        bit_out <= shreg[b - 2'd1];
                    end else begin
                        b <= 2'd3;
                        d <= D_LAST;
                        if (pend_full) begin
                            shreg   <= pend;
                            bit_out <= pend[3];
                            if (sym_vld)
                                pend <= sym;
                            else
                                pend_full <= 1'b0;
                        end else if (sym_vld) begin
                            shreg   <= sym;
                            bit_out <= sym[3];
                        end else begin
                            state   <= ST_IDLE;
                            bit_out <= 1'b0;
                            bit_vld <= 1'b0;
                        end
                    end
                    if (sym_vld && !fin) begin
                        if (!pend_full) begin
                            pend      <= sym;
                            pend_full <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qam16_judge.sv
// Bench for qam16_judge: vector table, directed timing sequences and random traffic vs a schedule model.
module tb_qam16_judge;
    import qam16_pkg::*;

    localparam int DIV     = 2;
    localparam int SYM_CYC = 4 * DIV;
    localparam int NEVER   = 32'h3fff_ffff;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] din_i, din_q, mean_i, mean_q;
    logic                 sym_stb;
    logic [3:0]           sym;
    logic                 sym_vld, bit_out, bit_vld, overrun;

    qam16_judge #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .din_i(din_i), .din_q(din_q), .mean_i(mean_i), .mean_q(mean_q),
        .sym_stb(sym_stb), .sym(sym), .sym_vld(sym_vld),
        .bit_out(bit_out), .bit_vld(bit_vld), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference slicer from the decision rules, in plain integer arithmetic
    function automatic logic [1:0] ref_level(input longint x, input longint mean);
        logic [1:0] gray [4];
        longint g;
        int k;
        gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
        g = (mean > 0) ? mean : 0;
        if (g == 0)
            k = (x < 0) ? 1 : 3;
        else
            k = ((x >= -g) ? 1 : 0) + ((x >= 0) ? 1 : 0) + ((x >= g) ? 1 : 0);
        return gray[k];
    endfunction

    // Schedule model: each accepted symbol owns SYM_CYC cycles starting at 'start'
    typedef struct { int start; logic [3:0] s; } slot_t;
    slot_t      sched[$];
    logic [3:0] m_sym;
    bit         m_prev_stb;
    int         m_ovr_from;

    always @(negedge clk) begin : monitor
        int c, v, e_last, bidx;
        bit ev, eb, drop;
        logic [3:0] s;
        if (mon_en) begin
            if (!rst_n) begin
                sched.delete();
                m_sym = 4'd0;
                m_prev_stb = 1'b0;
                m_ovr_from = NEVER;
                chk("rst_sym", int'(sym), 0);
                chk("rst_sym_vld", int'(sym_vld), 0);
                chk("rst_bit_out", int'(bit_out), 0);
                chk("rst_bit_vld", int'(bit_vld), 0);
                chk("rst_overrun", int'(overrun), 0);
            end else begin
                c  = cyc;
                ev = 1'b0;
                eb = 1'b0;
                foreach (sched[i]) begin
                    if (c >= sched[i].start && c < sched[i].start + SYM_CYC) begin
                        ev   = 1'b1;
                        bidx = 3 - (c - sched[i].start) / DIV;
                        eb   = sched[i].s[bidx];
                    end
                end
                chk("sym_vld", int'(sym_vld), int'(m_prev_stb));
                chk("sym", int'(sym), int'(m_sym));
                chk("bit_vld", int'(bit_vld), int'(ev));
                chk("bit_out", int'(bit_out), int'(eb));
                chk("overrun", int'(overrun), (c >= m_ovr_from) ? 1 : 0);

                m_prev_stb = sym_stb;
                if (sym_stb) begin
                    v = c + 1;
                    s = {ref_level(longint'(din_i), longint'(mean_i)),
                         ref_level(longint'(din_q), longint'(mean_q))};
                    m_sym  = s;
                    drop   = 1'b0;
                    e_last = -1;
                    foreach (sched[i]) begin
                        if (sched[i].start > v + 1) drop = 1'b1;
                        e_last = sched[i].start + SYM_CYC - 1;
                    end
                    if (drop) begin
                        if (m_ovr_from == NEVER) m_ovr_from = v + 1;
                    end else begin
                        sched.push_back('{start: ((e_last + 1) > (v + 1)) ? e_last + 1 : v + 1, s: s});
                    end
                end
                while (sched.size() > 0 && sched[0].start + SYM_CYC < c)
                    void'(sched.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int di, input int dq, input int mi, input int mq);
        din_i  = DW'(di);
        din_q  = DW'(dq);
        mean_i = DW'(mi);
        mean_q = DW'(mq);
    endtask

    task automatic strobe_one();
        sym_stb = 1'b1;
        tick(1);
        sym_stb = 1'b0;
    endtask

    task automatic do_reset();
        sym_stb = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    function automatic logic signed [DW-1:0] pick_mean();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return DW'(-int'($urandom_range(1, 1 << 20)));
            2:       return DW'((1 << 25) - 1);
            default: return DW'(int'($urandom_range(1, 1 << 20)));
        endcase
    endfunction

    function automatic logic signed [DW-1:0] pick_x(input logic signed [DW-1:0] m);
        case ($urandom_range(0, 7))
            0:       return m;
            1:       return m - 1;
            2:       return -m;
            3:       return -m - 1;
            4:       return '0;
            5:       return '1;
            default: return DW'(int'($urandom_range(0, 1 << 25)) - (1 << 24));
        endcase
    endfunction

    typedef struct { int di; int dq; int mi; int mq; logic [3:0] exp; } vec_t;
    vec_t tbl[10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        logic [3:0] sb;
        int pct [3];

        tbl[0] = '{1000,  -1001, 1000, 1000, 4'b1000};
        tbl[1] = '{999,   -1001, 1000, 1000, 4'b1100};
        tbl[2] = '{0,     -1001, 1000, 1000, 4'b1100};
        tbl[3] = '{-1,    -1001, 1000, 1000, 4'b0100};
        tbl[4] = '{-1000, -1001, 1000, 1000, 4'b0100};
        tbl[5] = '{-1001, -1001, 1000, 1000, 4'b0000};
        tbl[6] = '{-1,    5,     -500, 1000, 4'b0111};
        tbl[7] = '{0,     5,     -500, 1000, 4'b1011};
        tbl[8] = '{-7,    0,     0,    -3,   4'b0110};
        tbl[9] = '{-(1 << 25), (1 << 25) - 1, (1 << 25) - 1, (1 << 25) - 1, 4'b0010};

        rst_n   = 1'b1;
        sym_stb = 1'b0;
        set_in(0, 0, 0, 0);
        mon_en  = 1'b1;
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].di, tbl[i].dq, tbl[i].mi, tbl[i].mq);
            strobe_one();
            @(negedge clk);
            chk("tbl_sym_vld", int'(sym_vld), 1);
            chk($sformatf("tbl_sym[%0d]", i), int'(sym), int'(tbl[i].exp));
            tick(SYM_CYC + 2);
        end

        // Serial timing: symbol 1011 -> bits 1,1,0,0,1,1,1,1 in cycles t+2..t+9
        pat = 8'b11001111;
        set_in(1000, 5, 1000, 1000);
        strobe_one();
        @(negedge clk);
        chk("ser_vld_t1", int'(bit_vld), 0);
        for (int k = 0; k < 8; k++) begin
            tick(1);
            @(negedge clk);
            chk("ser_vld", int'(bit_vld), 1);
            chk("ser_bit", int'(bit_out), int'(pat[7 - k]));
        end
        tick(1);
        @(negedge clk);
        chk("ser_vld_end", int'(bit_vld), 0);
        tick(4);

        // Back-to-back: A at t, B (0001) at t+4 -> B gapless from t+10
        sb = 4'b0001;
        set_in(1000, 5, 1000, 1000);
        strobe_one();
        tick(3);
        set_in(-2000, -5, 1000, 1000);
        strobe_one();
        for (int r = 5; r <= 18; r++) begin
            @(negedge clk);
            chk("b2b_vld", int'(bit_vld), (r <= 17) ? 1 : 0);
            if (r >= 10 && r <= 17)
                chk("b2b_bit", int'(bit_out), int'(sb[3 - (r - 10) / DIV]));
            chk("b2b_ovr", int'(overrun), 0);
            tick(1);
        end
        tick(2);

        // Overrun: strobes at t, t+2, t+4 -> third dropped, second at t+10..t+17
        sb = 4'b0111;
        set_in(1000, 5, 1000, 1000);
        strobe_one();
        tick(1);
        set_in(-1, 5, 1000, 1000);
        strobe_one();
        tick(1);
        set_in(-2000, -2000, 1000, 1000);
        strobe_one();
        for (int r = 5; r <= 18; r++) begin
            @(negedge clk);
            chk("ovr_flag", int'(overrun), (r >= 6) ? 1 : 0);
            chk("ovr_vld", int'(bit_vld), (r <= 17) ? 1 : 0);
            if (r >= 10 && r <= 17)
                chk("ovr_bit", int'(bit_out), int'(sb[3 - (r - 10) / DIV]));
            tick(1);
        end
        tick(10);
        @(negedge clk);
        chk("ovr_sticky", int'(overrun), 1);

        // Reset mid-shift: outputs clear immediately, nothing follows release
        tick(1);
        set_in(1000, 5, 1000, 1000);
        strobe_one();
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("arst_sym", int'(sym), 0);
        chk("arst_bit_vld", int'(bit_vld), 0);
        chk("arst_bit_out", int'(bit_out), 0);
        chk("arst_overrun", int'(overrun), 0);
        tick(2);
        rst_n = 1'b1;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            chk("post_rst_vld", int'(bit_vld), 0);
            tick(1);
        end

        // Random traffic at three strobe densities
        pct[0] = 5; pct[1] = 15; pct[2] = 40;
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int n = 0; n < 1000; n++) begin
                mean_i  = pick_mean();
                mean_q  = pick_mean();
                din_i   = pick_x(mean_i);
                din_q   = pick_x(mean_q);
                sym_stb = ($urandom_range(0, 99) < pct[blk]);
                tick(1);
            end
            sym_stb = 1'b0;
            tick(SYM_CYC * 3);
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
